// File: rtl/vrf_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vrf_bank_scheduler
// Purpose  : Per-bank arbiter for a banked vector register file. Every bank
//            picks at most one winner per cycle among the read and write
//            requesters that target it. Writes beat reads unless the bank's
//            read starve counter has reached StarveLimit. Each class is
//            round-robin inside a bank. Read grants come back as a registered
//            valid together with the bank that was granted.
// Ports    : clk_i, rst_i (async, active-high)
//            rd_req_i/rd_bank_i   read requests and their target banks
//            wr_req_i/wr_bank_i   write requests and their target banks
//            rd_gnt_o/wr_gnt_o    combinational grants
//            bank_req_o/bank_wen_o/bank_src_o  per-bank access, write flag
//                                              and winning requester
//            rd_rvalid_o/rd_rbank_o  registered read return
//            stat_conflict_o      per-bank conflict counters
// Options  : define VRF_BANK_SCHED_STATS_EN to build the per-bank 16-bit
//            saturating conflict counters. Without it the counters are not
//            built and stat_conflict_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vrf_bank_scheduler #(
  parameter int unsigned NrBank      = 4,
  parameter int unsigned NrRdReq     = 3,
  parameter int unsigned NrWrReq     = 2,
  parameter int unsigned StarveLimit = 3,
  localparam int unsigned c_bank_w   = $clog2(NrBank),
  localparam int unsigned c_src_w    = (NrRdReq + NrWrReq > 1) ? $clog2(NrRdReq + NrWrReq) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NrRdReq-1:0]               rd_req_i,
  input  logic [NrRdReq-1:0][c_bank_w-1:0] rd_bank_i,
  input  logic [NrWrReq-1:0]               wr_req_i,
  input  logic [NrWrReq-1:0][c_bank_w-1:0] wr_bank_i,
  output logic [NrRdReq-1:0]               rd_gnt_o,
  output logic [NrWrReq-1:0]               wr_gnt_o,
  output logic [NrBank-1:0]                bank_req_o,
  output logic [NrBank-1:0]                bank_wen_o,
  output logic [NrBank-1:0][c_src_w-1:0]   bank_src_o,
  output logic [NrRdReq-1:0]               rd_rvalid_o,
  output logic [NrRdReq-1:0][c_bank_w-1:0] rd_rbank_o,
  output logic [NrBank-1:0][15:0]          stat_conflict_o
);

  localparam int unsigned c_rd_ptr_w = (NrRdReq > 1) ? $clog2(NrRdReq) : 1;
  localparam int unsigned c_wr_ptr_w = (NrWrReq > 1) ? $clog2(NrWrReq) : 1;
  localparam int unsigned c_cnt_w    = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;

  logic [NrBank-1:0][NrRdReq-1:0]    w_rd_mask;
  logic [NrBank-1:0][NrWrReq-1:0]    w_wr_mask;
  logic [NrBank-1:0]                 w_rd_found, w_wr_found;
  logic [NrBank-1:0]                 w_rd_sel, w_wr_sel;
  logic [NrBank-1:0][c_rd_ptr_w-1:0] w_rd_win, r_rd_ptr;
  logic [NrBank-1:0][c_wr_ptr_w-1:0] w_wr_win, r_wr_ptr;
  logic [NrBank-1:0][c_cnt_w-1:0]    r_starve;

  // --------------------------------------------------------------------------
  // Combinational arbitration, one independent arbiter per bank.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_gnt_o   = '0;
    wr_gnt_o   = '0;
    bank_req_o = '0;
    bank_wen_o = '0;
    bank_src_o = '0;
    w_rd_mask  = '0;
    w_wr_mask  = '0;
    w_rd_found = '0;
    w_wr_found = '0;
    w_rd_win   = '0;
    w_wr_win   = '0;
    w_rd_sel   = '0;
    w_wr_sel   = '0;
    for (int b = 0; b < NrBank; b++) begin
      for (int r = 0; r < NrRdReq; r++)
        w_rd_mask[b][r] = rd_req_i[r] && (rd_bank_i[r] == c_bank_w'(b));
      for (int w = 0; w < NrWrReq; w++)
        w_wr_mask[b][w] = wr_req_i[w] && (wr_bank_i[w] == c_bank_w'(b));

      // Round-robin by two descending scans: the first leaves the lowest
      // requester overall (the wrap-around choice), the second overrides it
      // with the lowest requester at or above the pointer when one exists.
      for (int r = NrRdReq - 1; r >= 0; r--)
        if (w_rd_mask[b][r]) begin
          w_rd_found[b] = 1'b1;
          w_rd_win[b]   = c_rd_ptr_w'(r);
        end
      for (int r = NrRdReq - 1; r >= 0; r--)
        if (w_rd_mask[b][r] && (c_rd_ptr_w'(r) >= r_rd_ptr[b]))
          w_rd_win[b] = c_rd_ptr_w'(r);

      for (int w = NrWrReq - 1; w >= 0; w--)
        if (w_wr_mask[b][w]) begin
          w_wr_found[b] = 1'b1;
          w_wr_win[b]   = c_wr_ptr_w'(w);
        end
      for (int w = NrWrReq - 1; w >= 0; w--)
        if (w_wr_mask[b][w] && (c_wr_ptr_w'(w) >= r_wr_ptr[b]))
          w_wr_win[b] = c_wr_ptr_w'(w);

      // Writes win unless reads are pending on a bank whose reads have been
      // starved for StarveLimit cycles.
      w_wr_sel[b] = w_wr_found[b] &&
                    !(w_rd_found[b] && (r_starve[b] == c_cnt_w'(StarveLimit)));
      w_rd_sel[b] = w_rd_found[b] && !w_wr_sel[b];

      bank_req_o[b] = w_rd_sel[b] | w_wr_sel[b];
      bank_wen_o[b] = w_wr_sel[b];
      if (w_wr_sel[b])
        bank_src_o[b] = c_src_w'(NrRdReq) + c_src_w'(w_wr_win[b]);
      else if (w_rd_sel[b])
        bank_src_o[b] = c_src_w'(w_rd_win[b]);

      for (int r = 0; r < NrRdReq; r++)
        if (w_rd_sel[b] && (w_rd_win[b] == c_rd_ptr_w'(r)))
          rd_gnt_o[r] = 1'b1;
      for (int w = 0; w < NrWrReq; w++)
        if (w_wr_sel[b] && (w_wr_win[b] == c_wr_ptr_w'(w)))
          wr_gnt_o[w] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, starve counters and the registered read return.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_starve    <= '0;
      rd_rvalid_o <= '0;
      rd_rbank_o  <= '0;
    end else begin
      for (int b = 0; b < NrBank; b++) begin
        if (w_rd_sel[b])
          r_rd_ptr[b] <= (w_rd_win[b] == c_rd_ptr_w'(NrRdReq - 1)) ? '0
                                                                 : w_rd_win[b] + c_rd_ptr_w'(1);
        if (w_wr_sel[b])
          r_wr_ptr[b] <= (w_wr_win[b] == c_wr_ptr_w'(NrWrReq - 1)) ? '0
                                                                 : w_wr_win[b] + c_wr_ptr_w'(1);
        // Count only cycles where a read waited and lost; saturate at the limit.
        if (w_rd_found[b] && !w_rd_sel[b]) begin
          if (r_starve[b] != c_cnt_w'(StarveLimit))
            r_starve[b] <= r_starve[b] + c_cnt_w'(1);
        end else begin
          r_starve[b] <= '0;
        end
      end
      rd_rvalid_o <= rd_gnt_o;
      for (int r = 0; r < NrRdReq; r++)
        if (rd_gnt_o[r])
          rd_rbank_o[r] <= rd_bank_i[r];
    end
  end

`ifdef VRF_BANK_SCHED_STATS_EN
  // A conflict cycle is any cycle with two or more requesters on one bank.
  logic [NrBank-1:0]       w_conflict;
  logic [NrBank-1:0][15:0] r_conflict;

  always_comb begin
    w_conflict = '0;
    for (int b = 0; b < NrBank; b++)
      w_conflict[b] = ($countones({w_rd_mask[b], w_wr_mask[b]}) >= 2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict <= '0;
    end else begin
      for (int b = 0; b < NrBank; b++)
        if (w_conflict[b] && (r_conflict[b] != 16'hFFFF))
          r_conflict[b] <= r_conflict[b] + 16'd1;
    end
  end

  assign stat_conflict_o = r_conflict;
`else
  assign stat_conflict_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vrf_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vrf_bank_scheduler
// Purpose  : Self-checking bench for vrf_bank_scheduler (default parameters).
//            A table of hand-derived vectors, directed multi-cycle sequences
//            and random traffic, all compared against a queue-based reference
//            model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vrf_bank_scheduler;
  localparam int NB = 4, NR = 3, NW = 2, BW = 2, SW = 3, LIM = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NR-1:0]           rd_req;
  logic [NR-1:0][BW-1:0]   rd_bank;
  logic [NW-1:0]           wr_req;
  logic [NW-1:0][BW-1:0]   wr_bank;
  logic [NR-1:0]           rd_gnt;
  logic [NW-1:0]           wr_gnt;
  logic [NB-1:0]           bank_req, bank_wen;
  logic [NB-1:0][SW-1:0]   bank_src;
  logic [NR-1:0]           rd_rvalid;
  logic [NR-1:0][BW-1:0]   rd_rbank;
  logic [NB-1:0][15:0]     stat;

  vrf_bank_scheduler #(.NrBank(NB), .NrRdReq(NR), .NrWrReq(NW), .StarveLimit(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_bank_i(rd_bank), .wr_req_i(wr_req), .wr_bank_i(wr_bank),
    .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .bank_req_o(bank_req), .bank_wen_o(bank_wen),
    .bank_src_o(bank_src), .rd_rvalid_o(rd_rvalid), .rd_rbank_o(rd_rbank),
    .stat_conflict_o(stat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_rd_ptr[NB], m_wr_ptr[NB], m_starve[NB], m_conf[NB], m_rbank[NR];
  logic [NR-1:0] m_rvalid;
  // Model results for the current cycle
  logic [NR-1:0] e_rg;
  logic [NW-1:0] e_wg;
  logic [NB-1:0] e_breq, e_wen;
  int  e_src[NB], e_rwin[NB], e_wwin[NB], e_nreq[NB];
  bit  e_rd_sel[NB], e_wr_sel[NB], e_rpend[NB];
  // DUT samples taken at the checking point of the last cycle
  logic [NR-1:0]         s_rg, s_rv;
  logic [NW-1:0]         s_wg;
  logic [NB-1:0]         s_breq, s_wen;
  logic [NB-1:0][SW-1:0] s_src;
  logic [NR-1:0][BW-1:0] s_rbank;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest queued index at or above ptr, otherwise wrap to the lowest.
  function automatic int pick(input int q[$], input int ptr);
    foreach (q[i]) if (q[i] >= ptr) return q[i];
    return q[0];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_rd_ptr[b] = 0; m_wr_ptr[b] = 0; m_starve[b] = 0; m_conf[b] = 0;
    end
    for (int r = 0; r < NR; r++) m_rbank[r] = 0;
    m_rvalid = '0;
  endtask

  task automatic model_eval();
    e_rg = '0; e_wg = '0; e_breq = '0; e_wen = '0;
    for (int b = 0; b < NB; b++) begin
      int rq[$];
      int wq[$];
      for (int r = 0; r < NR; r++) if (rd_req[r] && int'(rd_bank[r]) == b) rq.push_back(r);
      for (int w = 0; w < NW; w++) if (wr_req[w] && int'(wr_bank[w]) == b) wq.push_back(w);
      e_nreq[b] = rq.size() + wq.size();
      e_rpend[b] = (rq.size() > 0);
      e_rd_sel[b] = 0; e_wr_sel[b] = 0; e_src[b] = 0; e_rwin[b] = 0; e_wwin[b] = 0;
      if (wq.size() > 0 && !(rq.size() > 0 && m_starve[b] == LIM)) begin
        e_wr_sel[b] = 1;
        e_wwin[b] = pick(wq, m_wr_ptr[b]);
        e_src[b] = NR + e_wwin[b];
        e_breq[b] = 1'b1; e_wen[b] = 1'b1;
        for (int w = 0; w < NW; w++) if (w == e_wwin[b]) e_wg[w] = 1'b1;
      end else if (rq.size() > 0) begin
        e_rd_sel[b] = 1;
        e_rwin[b] = pick(rq, m_rd_ptr[b]);
        e_src[b] = e_rwin[b];
        e_breq[b] = 1'b1;
        for (int r = 0; r < NR; r++) if (r == e_rwin[b]) e_rg[r] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    for (int b = 0; b < NB; b++) begin
      if (e_rd_sel[b]) m_rd_ptr[b] = (e_rwin[b] + 1) % NR;
      if (e_wr_sel[b]) m_wr_ptr[b] = (e_wwin[b] + 1) % NW;
      if (e_rpend[b] && !e_rd_sel[b]) m_starve[b] = (m_starve[b] < LIM) ? m_starve[b] + 1 : LIM;
      else m_starve[b] = 0;
`ifdef VRF_BANK_SCHED_STATS_EN
      if (e_nreq[b] >= 2 && m_conf[b] < 65535) m_conf[b]++;
`endif
    end
    for (int r = 0; r < NR; r++) if (e_rg[r]) m_rbank[r] = int'(rd_bank[r]);
    m_rvalid = e_rg;
  endtask

  task automatic check_all();
    chk("rd_gnt", 64'(rd_gnt), 64'(e_rg));
    chk("wr_gnt", 64'(wr_gnt), 64'(e_wg));
    chk("bank_req", 64'(bank_req), 64'(e_breq));
    chk("bank_wen", 64'(bank_wen), 64'(e_wen));
    for (int b = 0; b < NB; b++) begin
      chk("bank_src", 64'(bank_src[b]), 64'(e_src[b]));
      chk("stat_conflict", 64'(stat[b]), 64'(m_conf[b]));
    end
    chk("rd_rvalid", 64'(rd_rvalid), 64'(m_rvalid));
    for (int r = 0; r < NR; r++)
      if (m_rvalid[r]) chk("rd_rbank", 64'(rd_rbank[r]), 64'(m_rbank[r]));
  endtask

  // One clock: drive just after the rising edge, check on the falling edge.
  task automatic cycle(input logic [NR-1:0] rq, input logic [NR-1:0][BW-1:0] rb,
                       input logic [NW-1:0] wq, input logic [NW-1:0][BW-1:0] wb);
    rd_req = rq; rd_bank = rb; wr_req = wq; wr_bank = wb;
    @(negedge clk);
    model_eval();
    check_all();
    s_rg = rd_gnt; s_wg = wr_gnt; s_breq = bank_req; s_wen = bank_wen;
    s_src = bank_src; s_rv = rd_rvalid; s_rbank = rd_rbank;
    @(posedge clk);
    if (!rst) model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_req = '0; rd_bank = '0; wr_req = '0; wr_bank = '0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0]         rq;
    logic [NR-1:0][BW-1:0] rb;
    logic [NW-1:0]         wq;
    logic [NW-1:0][BW-1:0] wb;
    logic [NR-1:0]         e_rg;
    logic [NW-1:0]         e_wg;
    logic [NB-1:0]         e_breq;
    logic [NB-1:0]         e_wen;
    logic [NB-1:0][SW-1:0] e_src;
    logic [NR-1:0]         e_rv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Sequential vectors from reset; packing is {rd2,rd1,rd0}, {wr1,wr0}, {b3..b0}.
    vecs[0] = '{3'b000, {2'd0,2'd0,2'd0}, 2'b00, {2'd0,2'd0}, 3'b000, 2'b00, 4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 3'b000};
    vecs[1] = '{3'b011, {2'd0,2'd1,2'd0}, 2'b11, {2'd3,2'd2}, 3'b011, 2'b11, 4'b1111, 4'b1100, {3'd4,3'd3,3'd1,3'd0}, 3'b000};
    vecs[2] = '{3'b011, {2'd0,2'd0,2'd0}, 2'b01, {2'd0,2'd0}, 3'b000, 2'b01, 4'b0001, 4'b0001, {3'd0,3'd0,3'd0,3'd3}, 3'b011};
    vecs[3] = '{3'b011, {2'd0,2'd0,2'd0}, 2'b01, {2'd0,2'd0}, 3'b000, 2'b01, 4'b0001, 4'b0001, {3'd0,3'd0,3'd0,3'd3}, 3'b000};
    vecs[4] = '{3'b011, {2'd0,2'd0,2'd0}, 2'b01, {2'd0,2'd0}, 3'b000, 2'b01, 4'b0001, 4'b0001, {3'd0,3'd0,3'd0,3'd3}, 3'b000};
    vecs[5] = '{3'b011, {2'd0,2'd0,2'd0}, 2'b01, {2'd0,2'd0}, 3'b010, 2'b00, 4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd1}, 3'b000};
    vecs[6] = '{3'b111, {2'd0,2'd0,2'd0}, 2'b00, {2'd0,2'd0}, 3'b100, 2'b00, 4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd2}, 3'b010};

    // Reset state
    rst = 1'b1; rd_req = '0; rd_bank = '0; wr_req = '0; wr_bank = '0;
    model_reset();
    #2;
    chk("reset_rvalid", 64'(rd_rvalid), 64'd0);
    chk("reset_rbank", 64'(rd_rbank), 64'd0);
    chk("reset_stat", 64'(stat), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].rq, vecs[i].rb, vecs[i].wq, vecs[i].wb);
      chk("tbl_rd_gnt", 64'(s_rg), 64'(vecs[i].e_rg));
      chk("tbl_wr_gnt", 64'(s_wg), 64'(vecs[i].e_wg));
      chk("tbl_bank_req", 64'(s_breq), 64'(vecs[i].e_breq));
      chk("tbl_bank_wen", 64'(s_wen), 64'(vecs[i].e_wen));
      chk("tbl_bank_src", 64'(s_src), 64'(vecs[i].e_src));
      chk("tbl_rvalid", 64'(s_rv), 64'(vecs[i].e_rv));
    end

    // rd0 vs wr0 on bank 1: three write wins, then a starved read wins
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(3'b001, {2'd0,2'd0,2'd1}, 2'b01, {2'd0,2'd1});
      chk("starve_wr0", 64'(s_wg[0]), 64'((i % 4) != 3));
      chk("starve_rd0", 64'(s_rg[0]), 64'((i % 4) == 3));
    end

    // Three reads held on bank 2: rotate rd0,rd1,rd2,rd0 with valid one cycle later
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(3'b111, {2'd2,2'd2,2'd2}, 2'b00, {2'd0,2'd0});
      if (i < 4) chk("rr_rd_gnt", 64'(s_rg), 64'(3'b001 << (i % 3)));
      if (i > 0) chk("rr_rvalid", 64'(s_rv), 64'(3'b001 << ((i - 1) % 3)));
    end

    // Reset while a read return is in flight
    do_reset();
    cycle(3'b001, {2'd0,2'd0,2'd1}, 2'b00, {2'd0,2'd0});
    chk("inflight_rvalid", 64'(rd_rvalid), 64'(3'b001));
    rd_req = 3'b110; rd_bank = '0;
    rst = 1'b1;
    #1;
    chk("async_rvalid_drop", 64'(rd_rvalid), 64'd0);
    chk("gnt_during_reset", 64'(rd_gnt), 64'(3'b010));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(3'b110, {2'd0,2'd0,2'd0}, 2'b00, {2'd0,2'd0});
    chk("post_rst_rd1", 64'(s_rg), 64'(3'b010));
    chk("post_rst_norv", 64'(s_rv), 64'd0);
    cycle(3'b110, {2'd0,2'd0,2'd0}, 2'b00, {2'd0,2'd0});
    chk("post_rst_rd2", 64'(s_rg), 64'(3'b100));
    cycle(3'b111, {2'd0,2'd0,2'd0}, 2'b00, {2'd0,2'd0});
    chk("post_rst_wrap_rd0", 64'(s_rg), 64'(3'b001));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(NR'($urandom), (NR*BW)'($urandom), NW'($urandom), (NW*BW)'($urandom));
    end

`ifdef VRF_BANK_SCHED_STATS_EN
    // Conflict counter saturation on bank 3
    do_reset();
    rd_req = 3'b011; rd_bank = {2'd0,2'd3,2'd3};
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stat_sat_b3", 64'(stat[3]), 64'hFFFF);
    for (int b = 0; b < 3; b++) chk("stat_other", 64'(stat[b]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
